ledip_axil_arbiter: RTL and testbench
=====================================

Name: ledip_axil_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer that shares one AXI4-Lite master port to the LEDip register slave (4 x 32-bit registers, offsets 0x0–0xC).
- Each requester issues single-word read or write commands over a simple valid/ready command interface and receives a one-cycle response pulse.
- The block converts each command into one complete AXI4-Lite transaction, one transaction outstanding at a time.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width and requester data width.
- C_S_AXI_ADDR_WIDTH, 4, AXI byte address width; covers the 4-register LEDip map.
- TIMEOUT_CYCLES, 255, watchdog limit; used only when LEDIP_ARB_TIMEOUT_EN is defined.

Ports:
- ACLK in 1: single clock.
- ARESET in 1: synchronous, active-high reset.
- req_valid in 2: per-requester command valid; bit i = requester i.
- req_write in 2: 1 = write, 0 = read.
- req_addr in 2*C_S_AXI_ADDR_WIDTH: packed byte addresses; requester i at [i*AW +: AW].
- req_wdata in 2*C_S_AXI_DATA_WIDTH: packed write data.
- req_ready out 2: one-cycle pulse when the command is captured.
- rsp_valid out 2: one-cycle completion pulse.
- rsp_rdata out C_S_AXI_DATA_WIDTH: read data, shared; valid with rsp_valid.
- rsp_resp out 2: AXI response code, shared; valid with rsp_valid.
- M_AXI_AWADDR out AW, M_AXI_AWPROT out 3, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1.
- M_AXI_WDATA out DW, M_AXI_WSTRB out DW/8, M_AXI_WVALID out 1, M_AXI_WREADY in 1.
- M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1.
- M_AXI_ARADDR out AW, M_AXI_ARPROT out 3, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1.
- M_AXI_RDATA in DW, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1.

Behaviour:
- Reset (ARESET=1 at a rising edge): state IDLE; all VALID/READY outputs, req_ready, rsp_valid, rsp_rdata and rsp_resp are 0; last_grant=1, so requester 0 wins the first contention.
- Reset mid-transaction: the same values apply on the next edge. The in-flight command is dropped and no rsp_valid is issued.
- States: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE:
  - Any req_valid raised: grant = the only valid requester; if both are valid, grant = ~last_grant.
  - Same edge: capture addr, wdata and write flag; pulse req_ready[grant] for 1 cycle; update last_grant.
  - Next state is WR_ADDR for a write, RD_ADDR for a read.
- Requester obligation: hold the command stable until req_ready; it may change it afterwards.
- Address and constant fields:
  - M_AXI_*ADDR = {captured_addr[AW-1:2], 2'b00}.
  - *PROT = 3'b000.
  - WSTRB = all ones.
- WR_ADDR:
  - AWVALID and WVALID assert together on state entry.
  - Each VALID drops the cycle after its own handshake; the two handshakes may complete in either order or in the same cycle.
  - Go to WR_RESP once both have completed.
- WR_RESP: BREADY=1; on BVALID, capture BRESP and go to RESP.
- RD_ADDR: ARVALID=1 until the ARREADY handshake, then go to RD_DATA.
- RD_DATA: RREADY=1; on RVALID, capture RDATA/RRESP and go to RESP.
- RESP:
  - rsp_valid[grant]=1 for exactly one cycle.
  - rsp_rdata/rsp_resp are held from capture until the next capture. For writes, rsp_rdata=0.
  - Next state IDLE; a new grant is possible on the following cycle.
- Minimum latency with zero-wait slave:
  - Write: req_ready to rsp_valid = 3 cycles.
  - Read: req_ready to rsp_valid = 3 cycles.
  - Back-to-back commands are spaced at least 5 cycles apart.
- VALIDs are never withdrawn before their handshake, except under the timeout option.

Optional Feature:
- LEDIP_ARB_TIMEOUT_EN defined:
  - A cycle counter clears on entry to WR_ADDR/RD_ADDR.
  - If a state reaches TIMEOUT_CYCLES cycles without completing, all AXI VALID/READY drop next edge and the block goes to RESP with rsp_resp=2'b10 (SLVERR), rsp_rdata=0.
  - This is a deliberate protocol exception for bus-hang recovery.
- Undefined: no counter; the block waits indefinitely.

Test Plan:
- Req0 writes 0x0000_0001 to 0x0, slave zero-wait -> one AW/W handshake with AWADDR=0x0, WDATA=0x1, WSTRB=0xF; rsp_valid=2'b01 three cycles after req_ready, rsp_resp=0.
- Req1 reads 0x4 after a prior write of 0x0000_0002 -> ARADDR=0x4; rsp_valid=2'b10, rsp_rdata=0x0000_0002.
- Both requesters valid in the same cycle right after reset -> req0 served first, then req1; a repeated tie alternates 0,1,0,1 over 4 commands.
- Slave holds WREADY low 3 cycles after AWREADY -> AWVALID drops after 1 cycle, WVALID held 4 cycles; a single rsp_valid, no duplicate AW.
- ARESET asserted in RD_DATA -> all outputs 0 next edge, no rsp_valid; a subsequent read to 0xC completes normally.
- With LEDIP_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never asserts BVALID -> BREADY drops after 16 cycles in WR_RESP; rsp_resp=2'b10, rsp_rdata=0.

Source files
------------

// File: rtl/ledip_axil_arbiter.sv
// Two-requester round-robin sequencer sharing one AXI4-Lite master port to the LEDip register slave.
// Define LEDIP_ARB_TIMEOUT_EN to enable the per-state bus-hang watchdog (TIMEOUT_CYCLES).

module ledip_axil_arbiter #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int TIMEOUT_CYCLES     = 255
) (
    input  logic                            ACLK,
    input  logic                            ARESET,

    input  logic [1:0]                      req_valid,
    input  logic [1:0]                      req_write,
    input  logic [2*C_S_AXI_ADDR_WIDTH-1:0] req_addr,
    input  logic [2*C_S_AXI_DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]                      req_ready,
    output logic [1:0]                      rsp_valid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,

    output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RESP
    } state_t;

    state_t        state;
    logic          grant;
    logic          last_grant;
    logic          g_nxt;
    logic          sel_write;
    logic [AW-3:0] cap_addr;
    logic [DW-1:0] cap_wdata;
    logic          aw_done;
    logic          w_done;
    logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic          aw_fin, w_fin;
    logic          tmo;
    logic          unused_addr_lsb;

    assign aw_hs  = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs   = M_AXI_WVALID  & M_AXI_WREADY;
    assign b_hs   = M_AXI_BREADY  & M_AXI_BVALID;
    assign ar_hs  = M_AXI_ARVALID & M_AXI_ARREADY;
    assign r_hs   = M_AXI_RREADY  & M_AXI_RVALID;
    assign aw_fin = aw_done | aw_hs;
    assign w_fin  = w_done  | w_hs;

    // On a tie the requester that did not win last time is served.
    assign g_nxt     = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    assign sel_write = req_write[g_nxt];

    assign M_AXI_AWADDR = {cap_addr, 2'b00};
    assign M_AXI_ARADDR = {cap_addr, 2'b00};
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WDATA  = cap_wdata;
    assign M_AXI_WSTRB  = '1;

    assign unused_addr_lsb = ^{req_addr[AW+1:AW], req_addr[1:0]};

`ifdef LEDIP_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             busy;
    logic             advance;

    assign busy    = (state == WR_ADDR) || (state == WR_RESP) ||
                     (state == RD_ADDR) || (state == RD_DATA);
    assign advance = ((state == WR_ADDR) && aw_fin && w_fin) ||
                     ((state == WR_RESP) && b_hs) ||
                     ((state == RD_ADDR) && ar_hs) ||
                     ((state == RD_DATA) && r_hs);
    // A completion in the last allowed cycle wins over the watchdog.
    assign tmo     = busy && !advance && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ACLK) begin
        if (ARESET || !busy || advance) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end
`else
    assign tmo = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state         <= IDLE;
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            req_ready     <= 2'b00;
            rsp_valid     <= 2'b00;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
        end else begin
            req_ready <= 2'b00;
            rsp_valid <= 2'b00;
            if (tmo) begin
                M_AXI_AWVALID    <= 1'b0;
                M_AXI_WVALID     <= 1'b0;
                M_AXI_BREADY     <= 1'b0;
                M_AXI_ARVALID    <= 1'b0;
                M_AXI_RREADY     <= 1'b0;
                rsp_valid[grant] <= 1'b1;
                rsp_resp         <= 2'b10;
                rsp_rdata        <= '0;
                state            <= RESP;
            end else begin
                case (state)
                    IDLE: begin
                        if (|req_valid) begin
                            grant            <= g_nxt;
                            last_grant       <= g_nxt;
                            req_ready[g_nxt] <= 1'b1;
                            cap_addr  <= g_nxt ? req_addr[2*AW-1:AW+2] : req_addr[AW-1:2];
                            cap_wdata <= g_nxt ? req_wdata[2*DW-1:DW]  : req_wdata[DW-1:0];
                            if (sel_write) begin
                                M_AXI_AWVALID <= 1'b1;
                                M_AXI_WVALID  <= 1'b1;
                                aw_done       <= 1'b0;
                                w_done        <= 1'b0;
                                state         <= WR_ADDR;
                            end else begin
                                M_AXI_ARVALID <= 1'b1;
                                state         <= RD_ADDR;
                            end
                        end
                    end
                    WR_ADDR: begin
                        if (aw_hs) begin
                            M_AXI_AWVALID <= 1'b0;
                            aw_done       <= 1'b1;
                        end
                        if (w_hs) begin
                            M_AXI_WVALID <= 1'b0;
                            w_done       <= 1'b1;
                        end
                        if (aw_fin && w_fin) begin
                            M_AXI_BREADY <= 1'b1;
                            state        <= WR_RESP;
                        end
                    end
                    WR_RESP: begin
                        if (b_hs) begin
                            M_AXI_BREADY     <= 1'b0;
                            rsp_resp         <= M_AXI_BRESP;
                            rsp_rdata        <= '0;
                            rsp_valid[grant] <= 1'b1;
                            state            <= RESP;
                        end
                    end
                    RD_ADDR: begin
                        if (ar_hs) begin
                            M_AXI_ARVALID <= 1'b0;
                            M_AXI_RREADY  <= 1'b1;
                            state         <= RD_DATA;
                        end
                    end
                    RD_DATA: begin
                        if (r_hs) begin
                            M_AXI_RREADY     <= 1'b0;
                            rsp_resp         <= M_AXI_RRESP;
                            rsp_rdata        <= M_AXI_RDATA;
                            rsp_valid[grant] <= 1'b1;
                            state            <= RESP;
                        end
                    end
                    RESP: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ledip_axil_arbiter.sv
// Bench for ledip_axil_arbiter: table of single commands against a registered-ready AXI4-Lite slave
// model, plus hand-written sequences for tie alternation, slow WREADY, mid-read reset and the watchdog.

module tb_ledip_axil_arbiter;

    localparam int AW = 4;
    localparam int DW = 32;

    logic            ACLK = 1'b0;
    logic            ARESET = 1'b1;
    logic [1:0]      req_valid = 2'b00;
    logic [1:0]      req_write = 2'b00;
    logic [2*AW-1:0] req_addr = '0;
    logic [2*DW-1:0] req_wdata = '0;
    logic [1:0]      req_ready, rsp_valid, rsp_resp;
    logic [DW-1:0]   rsp_rdata;
    logic [AW-1:0]   M_AXI_AWADDR, M_AXI_ARADDR;
    logic [2:0]      M_AXI_AWPROT, M_AXI_ARPROT;
    logic            M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
    logic [DW-1:0]   M_AXI_WDATA;
    logic [DW/8-1:0] M_AXI_WSTRB;

    logic            s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]      s_bresp, s_rresp;
    logic [DW-1:0]   s_rdata;

    always #5 ACLK = ~ACLK;

    ledip_axil_arbiter #(
        .C_S_AXI_DATA_WIDTH(DW),
        .C_S_AXI_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(s_awready),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(s_wready),
        .M_AXI_BRESP(s_bresp), .M_AXI_BVALID(s_bvalid), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(s_arready),
        .M_AXI_RDATA(s_rdata), .M_AXI_RRESP(s_rresp), .M_AXI_RVALID(s_rvalid),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    // Slave model: READY pulses one cycle after VALID is seen (plus a programmable wait),
    // B/R responses follow the handshake by one cycle.
    int         aw_dly = 0, w_dly = 0;
    bit         b_hang = 0, r_hang = 0;
    logic [1:0] cfg_resp = 2'b00;
    logic [DW-1:0] mem [4];
    int         aw_wc, w_wc;
    logic       got_aw, got_w;
    logic [AW-1:0] s_awaddr;
    logic [DW-1:0] s_wdata;
    logic       s_aw_hs, s_w_hs;
    logic [1:0] s_wa;
    logic [DW-1:0] s_wd;

    assign s_aw_hs = M_AXI_AWVALID && s_awready;
    assign s_w_hs  = M_AXI_WVALID && s_wready;
    assign s_wa    = s_aw_hs ? M_AXI_AWADDR[3:2] : s_awaddr[3:2];
    assign s_wd    = s_w_hs ? M_AXI_WDATA : s_wdata;

    always @(posedge ACLK) begin
        if (ARESET) begin
            s_awready <= 0; s_wready <= 0; s_bvalid <= 0; s_arready <= 0; s_rvalid <= 0;
            got_aw <= 0; got_w <= 0; aw_wc <= 0; w_wc <= 0;
            s_bresp <= 0; s_rresp <= 0; s_rdata <= 0;
        end else begin
            if (s_awready) s_awready <= 0;
            else if (M_AXI_AWVALID) begin
                if (aw_wc == aw_dly) begin s_awready <= 1; aw_wc <= 0; end
                else aw_wc <= aw_wc + 1;
            end
            if (s_wready) s_wready <= 0;
            else if (M_AXI_WVALID) begin
                if (w_wc == w_dly) begin s_wready <= 1; w_wc <= 0; end
                else w_wc <= w_wc + 1;
            end
            if (s_aw_hs) begin got_aw <= 1; s_awaddr <= M_AXI_AWADDR; end
            if (s_w_hs) begin got_w <= 1; s_wdata <= M_AXI_WDATA; end
            if ((got_aw || s_aw_hs) && (got_w || s_w_hs) && !s_bvalid && !b_hang) begin
                mem[s_wa] <= s_wd;
                s_bvalid <= 1; s_bresp <= cfg_resp;
                got_aw <= 0; got_w <= 0;
            end else if (s_bvalid && M_AXI_BREADY) s_bvalid <= 0;
            if (s_arready) s_arready <= 0;
            else if (M_AXI_ARVALID) s_arready <= 1;
            if (M_AXI_ARVALID && s_arready && !r_hang) begin
                s_rvalid <= 1; s_rdata <= mem[M_AXI_ARADDR[3:2]]; s_rresp <= cfg_resp;
            end else if (s_rvalid && M_AXI_RREADY) s_rvalid <= 0;
        end
    end

    // Bus monitor.
    int cyc = 0, awv_cyc = 0, wv_cyc = 0, br_cyc = 0, aw_hs_cnt = 0, ar_hs_cnt = 0;
    int rsp0_cnt = 0, rsp1_cnt = 0;
    logic [AW-1:0]   mon_awaddr, mon_araddr;
    logic [DW-1:0]   mon_wdata;
    logic [DW/8-1:0] mon_wstrb;

    always @(posedge ACLK) begin
        cyc <= cyc + 1;
        if (M_AXI_AWVALID) awv_cyc <= awv_cyc + 1;
        if (M_AXI_WVALID) wv_cyc <= wv_cyc + 1;
        if (M_AXI_BREADY) br_cyc <= br_cyc + 1;
        if (M_AXI_AWVALID && s_awready) begin aw_hs_cnt <= aw_hs_cnt + 1; mon_awaddr <= M_AXI_AWADDR; end
        if (M_AXI_WVALID && s_wready) begin mon_wdata <= M_AXI_WDATA; mon_wstrb <= M_AXI_WSTRB; end
        if (M_AXI_ARVALID && s_arready) begin ar_hs_cnt <= ar_hs_cnt + 1; mon_araddr <= M_AXI_ARADDR; end
        if (rsp_valid[0]) rsp0_cnt <= rsp0_cnt + 1;
        if (rsp_valid[1]) rsp1_cnt <= rsp1_cnt + 1;
    end

    int n_tests = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_expired(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic do_cmd(input int who, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, output int lat, output logic [1:0] rv,
                          output logic [DW-1:0] rd, output logic [1:0] rs, output logic rv_after);
        int  t0;
        bit  got;
        @(negedge ACLK);
        req_valid[who] = 1'b1;
        req_write[who] = wr;
        req_addr[who*AW +: AW] = addr;
        req_wdata[who*DW +: DW] = wdata;
        got = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge ACLK);
            if (req_ready[who]) begin got = 1; break; end
        end
        req_valid[who] = 1'b0;
        t0 = cyc;
        if (!got) bound_expired("req_ready wait");
        got = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge ACLK);
            if (rsp_valid != 2'b00) begin got = 1; break; end
        end
        if (!got) bound_expired("rsp_valid wait");
        lat = cyc - t0;
        rv = rsp_valid;
        rd = rsp_rdata;
        rs = rsp_resp;
        @(negedge ACLK);
        rv_after = |rsp_valid;
    endtask

    typedef struct packed {
        logic          who;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [1:0]    slv_resp;
        logic [DW-1:0] exp_rdata;
        logic [AW-1:0] exp_axaddr;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int lat;
        logic [1:0] rv, rs;
        logic [DW-1:0] rd;
        logic rva;
        int a0, w0, h0, r0, r1, b0;
        logic [1:0] gr_vec [4];
        int gr_cyc [4];
        logic [1:0] rsp_vec [4];
        logic [DW-1:0] rsp_dat [4];
        int n_gr, n_rsp;
        bit got;

        //          who  wr   addr   wdata          resp   exp_rdata      axaddr
        vecs[0] = {1'b0, 1'b1, 4'h0, 32'h0000_0001, 2'b00, 32'h0000_0000, 4'h0};
        vecs[1] = {1'b0, 1'b1, 4'h4, 32'h0000_0002, 2'b00, 32'h0000_0000, 4'h4};
        vecs[2] = {1'b1, 1'b0, 4'h4, 32'h0000_0000, 2'b00, 32'h0000_0002, 4'h4};
        vecs[3] = {1'b1, 1'b1, 4'hF, 32'hDEAD_BEEF, 2'b00, 32'h0000_0000, 4'hC};
        vecs[4] = {1'b0, 1'b0, 4'h1, 32'h0000_0000, 2'b00, 32'h0000_0001, 4'h0};
        vecs[5] = {1'b1, 1'b0, 4'hE, 32'h0000_0000, 2'b00, 32'hDEAD_BEEF, 4'hC};
        vecs[6] = {1'b0, 1'b1, 4'h8, 32'hA5A5_0F0F, 2'b10, 32'h0000_0000, 4'h8};
        vecs[7] = {1'b1, 1'b0, 4'hA, 32'h0000_0000, 2'b01, 32'hA5A5_0F0F, 4'h8};

        repeat (3) @(negedge ACLK);
        check("rst req_ready/rsp_valid", {req_ready, rsp_valid}, 0);
        check("rst rsp_rdata/rsp_resp", {rsp_rdata, rsp_resp}, 0);
        check("rst axi valid/ready",
              {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
        ARESET = 1'b0;

        for (int i = 0; i < 8; i++) begin
            cfg_resp = vecs[i].slv_resp;
            a0 = aw_hs_cnt + ar_hs_cnt;
            do_cmd(int'(vecs[i].who), vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, rv, rd, rs, rva);
            check($sformatf("vec%0d latency", i), lat, 3);
            check($sformatf("vec%0d rsp_valid", i), rv, vecs[i].who ? 2'b10 : 2'b01);
            check($sformatf("vec%0d rsp_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d rsp_resp", i), rs, vecs[i].slv_resp);
            check($sformatf("vec%0d rsp pulse width", i), rva, 0);
            check($sformatf("vec%0d addr handshakes", i), aw_hs_cnt + ar_hs_cnt - a0, 1);
            if (vecs[i].wr) begin
                check($sformatf("vec%0d AWADDR", i), mon_awaddr, vecs[i].exp_axaddr);
                check($sformatf("vec%0d WDATA", i), mon_wdata, vecs[i].wdata);
                check($sformatf("vec%0d WSTRB", i), mon_wstrb, 4'hF);
                check($sformatf("vec%0d AWPROT", i), M_AXI_AWPROT, 0);
            end else begin
                check($sformatf("vec%0d ARADDR", i), mon_araddr, vecs[i].exp_axaddr);
                check($sformatf("vec%0d ARPROT", i), M_AXI_ARPROT, 0);
            end
        end
        cfg_resp = 2'b00;

        // Slave withholds WREADY three cycles beyond AWREADY.
        w_dly = 3;
        a0 = awv_cyc; w0 = wv_cyc; h0 = aw_hs_cnt; r0 = rsp0_cnt;
        do_cmd(0, 1'b1, 4'h8, 32'h0000_0055, lat, rv, rd, rs, rva);
        w_dly = 0;
        check("slow W AWVALID cycles", awv_cyc - a0, 2);
        check("slow W WVALID cycles", wv_cyc - w0, 5);
        check("slow W AW handshakes", aw_hs_cnt - h0, 1);
        check("slow W rsp pulses", rsp0_cnt - r0, 1);
        check("slow W rsp_valid", rv, 2'b01);

        // Reset while waiting for RVALID.
        r_hang = 1;
        @(negedge ACLK);
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[AW-1:0] = 4'h8;
        got = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge ACLK);
            if (req_ready[0]) req_valid[0] = 1'b0;
            if (M_AXI_RREADY) begin got = 1; break; end
        end
        req_valid[0] = 1'b0;
        if (!got) bound_expired("RREADY wait");
        r0 = rsp0_cnt; r1 = rsp1_cnt;
        ARESET = 1'b1;
        @(negedge ACLK);
        check("mid-rst req_ready/rsp_valid", {req_ready, rsp_valid}, 0);
        check("mid-rst rsp_rdata/rsp_resp", {rsp_rdata, rsp_resp}, 0);
        check("mid-rst axi valid/ready",
              {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
        ARESET = 1'b0;
        r_hang = 0;
        repeat (4) @(negedge ACLK);
        check("mid-rst no rsp pulse", (rsp0_cnt - r0) + (rsp1_cnt - r1), 0);
        do_cmd(1, 1'b0, 4'hC, 32'h0, lat, rv, rd, rs, rva);
        check("post-rst read latency", lat, 3);
        check("post-rst read rsp_valid", rv, 2'b10);
        check("post-rst read rdata", rd, 32'hDEAD_BEEF);
        check("post-rst ARADDR", mon_araddr, 4'hC);

        // Continuous tie right after reset: grants alternate 0,1,0,1 five cycles apart.
        @(negedge ACLK);
        ARESET = 1'b1;
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        req_write = 2'b00;
        req_addr = {4'h4, 4'h0};
        req_valid = 2'b11;
        n_gr = 0; n_rsp = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge ACLK);
            if (req_ready != 2'b00 && n_gr < 4) begin
                gr_vec[n_gr] = req_ready;
                gr_cyc[n_gr] = cyc;
                n_gr++;
                if (n_gr == 4) req_valid = 2'b00;
            end
            if (rsp_valid != 2'b00 && n_rsp < 4) begin
                rsp_vec[n_rsp] = rsp_valid;
                rsp_dat[n_rsp] = rsp_rdata;
                n_rsp++;
            end
            if (n_rsp == 4) break;
        end
        req_valid = 2'b00;
        if (n_gr < 4 || n_rsp < 4) bound_expired("tie sequence");
        for (int k = 0; k < n_gr; k++) begin
            check($sformatf("tie grant %0d", k), gr_vec[k], (k % 2) ? 2'b10 : 2'b01);
            if (k > 0) check($sformatf("tie spacing %0d", k), gr_cyc[k] - gr_cyc[k-1], 5);
        end
        for (int k = 0; k < n_rsp; k++) begin
            check($sformatf("tie rsp %0d", k), rsp_vec[k], (k % 2) ? 2'b10 : 2'b01);
            check($sformatf("tie rdata %0d", k), rsp_dat[k], (k % 2) ? 32'h2 : 32'h1);
        end

`ifdef LEDIP_ARB_TIMEOUT_EN
        // Slave never answers the write; the watchdog closes it out with SLVERR.
        b_hang = 1;
        b0 = br_cyc;
        do_cmd(0, 1'b1, 4'h0, 32'h0000_0007, lat, rv, rd, rs, rva);
        check("timeout BREADY cycles", br_cyc - b0, 16);
        check("timeout rsp_valid", rv, 2'b01);
        check("timeout rsp_resp", rs, 2'b10);
        check("timeout rsp_rdata", rd, 0);
        check("timeout BREADY dropped", M_AXI_BREADY, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
